// File: rtl/clock_divider_multi.sv
// ----------------------------------------------------------------------------
// clock_divider_multi
//
// Produces NUM_CH independently programmable integer clock dividers from
// clk_in. A newly written divisor is held as pending and is applied only at
// a period boundary. A boundary is terminal count, sync, the first edge after
// reset, or any edge of a stopped channel. Because of this, no output ever
// emits a runt pulse.
//
// Parameters
//   NUM_CH   number of divider channels
//   CNT_W    divisor/counter width; largest divisor is 2^CNT_W-1
//   DEF_DIV  divisor every channel holds after reset (>= 2)
//
// Ports
//   clk_in    master clock; all logic updates on its rising edge
//   reset     synchronous, active-high reset
//   sync      restart every running channel at phase 0 on the next edge
//   div_wr    one-cycle divisor write strobe
//   div_sel   channel addressed by div_wr (out-of-range values are ignored)
//   div_data  divisor value for div_wr (0 or 1 stops the channel)
//   div_busy  per channel: a written divisor has not been applied yet
//   clk_out   registered divided clocks, high while cnt < ceil(D/2)
//   tick      registered one-cycle pulse in the last cycle of each period
//   e_clk     6800-style E clock (clk_in/10, 6 low / 4 high); this port
//             exists only when CLKGEN_ECLK_EN is defined
// ----------------------------------------------------------------------------
module clock_divider_multi #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 8,
    parameter int DEF_DIV = 2,
    localparam int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              sync,
    input  logic              div_wr,
    input  logic [SEL_W-1:0]  div_sel,
    input  logic [CNT_W-1:0]  div_data,
    output logic [NUM_CH-1:0] div_busy,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
`ifdef CLKGEN_ECLK_EN
    ,
    output logic              e_clk
`endif
);

    logic [CNT_W-1:0]  cnt_q  [NUM_CH];
    logic [CNT_W-1:0]  cnt_d  [NUM_CH];
    logic [CNT_W-1:0]  div_q  [NUM_CH];
    logic [CNT_W-1:0]  div_d  [NUM_CH];
    logic [CNT_W-1:0]  pend_q [NUM_CH];
    logic [CNT_W-1:0]  pend_d [NUM_CH];
    logic [CNT_W-1:0]  half_d [NUM_CH];
    logic [NUM_CH-1:0] busy_q, busy_d;
    logic [NUM_CH-1:0] clk_q, clk_d;
    logic [NUM_CH-1:0] tick_q, tick_d;
    logic [NUM_CH-1:0] wr_hit, run_q, run_d, term, boundary;
    logic              started_q;
    logic              restart;

    // The first edge after reset behaves like sync. That is why clk_out rises
    // on that edge, with cnt=0, instead of one period later.
    assign restart = sync | ~started_q;

    // NOTE: every combinational output gets a default before any branch, so
    // that no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i]    = cnt_q[i];
            div_d[i]    = div_q[i];
            pend_d[i]   = pend_q[i];
            busy_d[i]   = busy_q[i];
            wr_hit[i]   = div_wr && (div_sel == SEL_W'(i));
            run_q[i]    = div_q[i] >= CNT_W'(2);
            term[i]     = run_q[i] && (cnt_q[i] == div_q[i] - CNT_W'(1));
            boundary[i] = restart || term[i] || !run_q[i];

            if (boundary[i]) begin
                // A pending divisor is applied here, and the new period starts.
                if (busy_q[i]) begin
                    div_d[i]  = pend_q[i];
                    busy_d[i] = 1'b0;
                end
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end

            // The write is evaluated after the apply step. A write in the
            // boundary cycle therefore stays pending until the next boundary.
            if (wr_hit[i]) begin
                pend_d[i] = div_data;
                busy_d[i] = 1'b1;
            end

            // Outputs are computed from the next state, so clk_out and tick
            // line up with the cnt value they describe.
            run_d[i]  = div_d[i] >= CNT_W'(2);
            half_d[i] = (div_d[i] >> 1) + {{(CNT_W-1){1'b0}}, div_d[i][0]};
            clk_d[i]  = run_d[i] && (cnt_d[i] < half_d[i]);
            tick_d[i] = run_d[i] && (cnt_d[i] == div_d[i] - CNT_W'(1));
        end
    end

    // NOTE: sequential state is updated only with non-blocking assignments.
    // This lets all registers sample the same pre-edge values.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            // NOTE: the per-channel register arrays are reset explicitly. A
            // pending divisor must not survive a reset, and the arrays are
            // only NUM_CH entries deep.
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]  <= '0;
                div_q[i]  <= CNT_W'(DEF_DIV);
                pend_q[i] <= '0;
            end
            busy_q    <= '0;
            clk_q     <= '0;
            tick_q    <= '0;
            started_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]  <= cnt_d[i];
                div_q[i]  <= div_d[i];
                pend_q[i] <= pend_d[i];
            end
            busy_q    <= busy_d;
            clk_q     <= clk_d;
            tick_q    <= tick_d;
            started_q <= 1'b1;
        end
    end

    assign div_busy = busy_q;
    assign clk_out  = clk_q;
    assign tick     = tick_q;

`ifdef CLKGEN_ECLK_EN
    // Private mod-10 counter. e_clk is low for counts 0-5 and high for 6-9.
    logic [3:0] e_cnt_q, e_cnt_d;
    logic       e_clk_q;

    always_comb begin
        if (sync || e_cnt_q == 4'd9) e_cnt_d = 4'd0;
        else                         e_cnt_d = e_cnt_q + 4'd1;
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            e_cnt_q <= 4'd0;
            e_clk_q <= 1'b0;
        end else begin
            e_cnt_q <= e_cnt_d;
            e_clk_q <= (e_cnt_d >= 4'd6);
        end
    end

    assign e_clk = e_clk_q;
`endif

endmodule

// File: tb/tb_clock_divider_multi.sv
// ----------------------------------------------------------------------------
// tb_clock_divider_multi
//
// Self-checking bench for clock_divider_multi with the default parameters.
// The checks are:
//   - a directed vector table covering reset, DEF_DIV toggling and a D=5
//     rewrite of channel 1
//   - hand sequences for last-write-wins, sync alignment, stop/restart,
//     reset while busy and the maximum divisor
//   - a randomized run compared against a reference model of periods
// The e_clk port is connected and checked only when CLKGEN_ECLK_EN is defined.
// ----------------------------------------------------------------------------
module tb_clock_divider_multi;

    localparam int NUM_CH  = 4;
    localparam int CNT_W   = 8;
    localparam int DEF_DIV = 2;
    localparam int SEL_W   = 2;

    logic              clk_in   = 1'b0;
    logic              reset    = 1'b1;
    logic              sync     = 1'b0;
    logic              div_wr   = 1'b0;
    logic [SEL_W-1:0]  div_sel  = '0;
    logic [CNT_W-1:0]  div_data = '0;
    logic [NUM_CH-1:0] div_busy, clk_out, tick;
`ifdef CLKGEN_ECLK_EN
    logic              e_clk;
`endif

    clock_divider_multi #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .DEF_DIV(DEF_DIV)
    ) dut (
        .clk_in  (clk_in),
        .reset   (reset),
        .sync    (sync),
        .div_wr  (div_wr),
        .div_sel (div_sel),
        .div_data(div_data),
        .div_busy(div_busy),
        .clk_out (clk_out),
`ifdef CLKGEN_ECLK_EN
        .e_clk   (e_clk),
`endif
        .tick    (tick)
    );

    always #5 clk_in = ~clk_in;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each channel is described by its divisor and its position within the
    // current period. A position of -1 means the channel produces no output.
    int m_d    [NUM_CH];
    int m_pos  [NUM_CH];
    int m_pend [NUM_CH];
    bit m_pv   [NUM_CH];
    bit m_started;
    int m_e;

    task automatic model_edge();
        bit new_per;
        bit rs;
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_d[c] = DEF_DIV; m_pos[c] = -1; m_pend[c] = 0; m_pv[c] = 0;
            end
            m_started = 0;
            m_e = 0;
        end else begin
            rs = sync || !m_started;
            m_started = 1;
            for (int c = 0; c < NUM_CH; c++) begin
                new_per = rs || (m_d[c] < 2) || (m_pos[c] == m_d[c] - 1);
                if (new_per) begin
                    if (m_pv[c]) begin
                        m_d[c] = m_pend[c];
                        m_pv[c] = 0;
                    end
                    m_pos[c] = (m_d[c] >= 2) ? 0 : -1;
                end else begin
                    m_pos[c] = m_pos[c] + 1;
                end
                if (div_wr && int'(div_sel) == c) begin
                    m_pend[c] = int'(div_data);
                    m_pv[c] = 1;
                end
            end
            m_e = sync ? 0 : (m_e + 1) % 10;
        end
    endtask

    function automatic logic [NUM_CH-1:0] exp_clk();
        logic [NUM_CH-1:0] r;
        for (int c = 0; c < NUM_CH; c++) r[c] = (m_pos[c] >= 0) && (2 * m_pos[c] < m_d[c]);
        return r;
    endfunction

    function automatic logic [NUM_CH-1:0] exp_tick();
        logic [NUM_CH-1:0] r;
        for (int c = 0; c < NUM_CH; c++) r[c] = (m_pos[c] >= 0) && (m_pos[c] == m_d[c] - 1);
        return r;
    endfunction

    function automatic logic [NUM_CH-1:0] exp_busy();
        logic [NUM_CH-1:0] r;
        for (int c = 0; c < NUM_CH; c++) r[c] = m_pv[c];
        return r;
    endfunction

    // One clock edge: update the model with the inputs in force at the edge,
    // then sample the DUT 1 ns later.
    task automatic step();
        @(posedge clk_in);
        model_edge();
        #1;
        check("model_clk",  32'(clk_out),  32'(exp_clk()));
        check("model_tick", 32'(tick),     32'(exp_tick()));
        check("model_busy", 32'(div_busy), 32'(exp_busy()));
`ifdef CLKGEN_ECLK_EN
        check("model_eclk", 32'(e_clk), 32'(m_e >= 6));
`endif
    endtask

    task automatic drive(input logic r, input logic s, input logic w,
                         input logic [SEL_W-1:0] sel, input logic [CNT_W-1:0] data);
        reset = r; sync = s; div_wr = w; div_sel = sel; div_data = data;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    // Step until div_busy[ch] clears, or the cycle budget expires.
    task automatic wait_busy_clear(input int ch, input int budget);
        int n = 0;
        while (div_busy[ch] && n < budget) begin
            step();
            n++;
        end
        check("busy_clear_timeout", 32'(div_busy[ch]), 32'd0);
    endtask

    typedef struct {
        logic              rst, syn, wr;
        logic [SEL_W-1:0]  sel;
        logic [CNT_W-1:0]  data;
        logic [NUM_CH-1:0] clk, tk, busy;
    } vec_t;

    vec_t tbl [11];

    initial begin
        int hi, lo, first_both, n;

        // Directed table: reset, DEF_DIV toggling, then ch1 rewritten to D=5.
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 4'b0000, 4'b0000, 4'b0000};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 4'b1111, 4'b0000, 4'b0000};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 4'b0000, 4'b1111, 4'b0000};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 4'b1111, 4'b0000, 4'b0000};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 2'd1, 8'd5, 4'b0000, 4'b1111, 4'b0010};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 4'b1111, 4'b0000, 4'b0000};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 4'b0010, 4'b1101, 4'b0000};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 4'b1111, 4'b0000, 4'b0000};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 4'b0000, 4'b1101, 4'b0000};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 4'b1101, 4'b0010, 4'b0000};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 4'b0010, 4'b1101, 4'b0000};

        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].rst, tbl[i].syn, tbl[i].wr, tbl[i].sel, tbl[i].data);
            step();
            check($sformatf("vec%0d_clk", i),  32'(clk_out),  32'(tbl[i].clk));
            check($sformatf("vec%0d_tick", i), 32'(tick),     32'(tbl[i].tk));
            check($sformatf("vec%0d_busy", i), 32'(div_busy), 32'(tbl[i].busy));
        end
        idle();

        // Last write wins. Write ch2=6 in its terminal-count cycle, so the
        // D=9 overwrite lands before the next boundary.
        n = 0;
        while (!tick[2] && n < 10) begin step(); n++; end
        check("ch2_tick_seen", 32'(tick[2]), 32'd1);
        drive(1'b0, 1'b0, 1'b1, 2'd2, 8'd6); step();
        check("ch2_busy_after_w6", 32'(div_busy[2]), 32'd1);
        drive(1'b0, 1'b0, 1'b1, 2'd2, 8'd9); step();
        check("ch2_busy_after_w9", 32'(div_busy[2]), 32'd1);
        idle(); step();
        check("ch2_applied", 32'(div_busy[2]), 32'd0);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("ch2_d9_k%0d", k), 32'(clk_out[2]), 32'((k % 9) < 5));
            step();
        end

        // Sync alignment: ch0 D=4, ch3 D=7, then tick coincidence after 28.
        drive(1'b0, 1'b0, 1'b1, 2'd0, 8'd4); step();
        drive(1'b0, 1'b0, 1'b1, 2'd3, 8'd7); step();
        idle();
        wait_busy_clear(0, 20);
        wait_busy_clear(3, 20);
        drive(1'b0, 1'b1, 1'b0, 2'd0, 8'd0); step();
        idle();
        check("sync_clk0", 32'(clk_out[0]), 32'd1);
        check("sync_clk3", 32'(clk_out[3]), 32'd1);
        first_both = -1;
        for (int k = 1; k <= 28; k++) begin
            step();
            if (first_both < 0 && tick[0] && tick[3]) first_both = k;
        end
        check("sync_tick_coincide", 32'(first_both), 32'd27);

        // Stop ch0 with D=0, restart it with D=3, then reset while busy.
        drive(1'b0, 1'b0, 1'b1, 2'd0, 8'd0); step();
        idle();
        wait_busy_clear(0, 20);
        for (int k = 0; k < 4; k++) begin
            step();
            check("ch0_stopped_clk", 32'(clk_out[0]), 32'd0);
            check("ch0_stopped_tick", 32'(tick[0]), 32'd0);
        end
        drive(1'b0, 1'b0, 1'b1, 2'd0, 8'd3); step();
        idle();
        check("ch0_w3_busy", 32'(div_busy[0]), 32'd1);
        check("ch0_w3_clk", 32'(clk_out[0]), 32'd0);
        step(); check("ch0_d3_c0", {30'd0, div_busy[0], clk_out[0]}, 32'b01);
        step(); check("ch0_d3_c1", 32'(clk_out[0]), 32'd1);
        step(); check("ch0_d3_c2", {30'd0, tick[0], clk_out[0]}, 32'b10);
        step(); check("ch0_d3_c3", 32'(clk_out[0]), 32'd1);
        drive(1'b0, 1'b0, 1'b1, 2'd0, 8'd9); step();
        check("ch0_w9_busy", 32'(div_busy[0]), 32'd1);
        drive(1'b1, 1'b0, 1'b0, 2'd0, 8'd0); step();
        check("rst_busy", 32'(div_busy), 32'd0);
        check("rst_clk", 32'(clk_out), 32'd0);
        idle(); step();
        check("rst_def_c0", 32'(clk_out), 32'(4'b1111));
        step();
        check("rst_def_c1", 32'(clk_out), 32'(4'b0000));
        check("rst_def_t1", 32'(tick), 32'(4'b1111));

        // Maximum divisor 255 on ch1: 128 high / 127 low.
        drive(1'b0, 1'b0, 1'b1, 2'd1, 8'd255); step();
        idle();
        wait_busy_clear(1, 10);
        hi = 0;
        while (clk_out[1] && hi < 400) begin hi++; step(); end
        lo = 0;
        while (!clk_out[1] && lo < 400) begin lo++; step(); end
        check("dmax_high", 32'(hi), 32'd128);
        check("dmax_low", 32'(lo), 32'd127);

        // Randomized run against the model.
        for (int k = 0; k < 4000; k++) begin
            drive(logic'($urandom_range(499) == 0),
                  logic'($urandom_range(39) == 0),
                  logic'($urandom_range(5) == 0),
                  SEL_W'($urandom_range(NUM_CH - 1)),
                  ($urandom_range(7) == 0) ? 8'd255 : 8'($urandom_range(12)));
            step();
        end
        idle();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
